// File: rtl/fp_wb_sched.sv
// FP write-back scheduler: round-robin arbitration of result sources onto the
// single register-file write port, plus pending-write tracking for issue hazards.
module fp_wb_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DEPTH-1:0]   req_wa,
    input  logic [NREQ*WIDTH-1:0]   req_wd,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    iss_valid,
    input  logic [DEPTH-1:0]        iss_rs1,
    input  logic [DEPTH-1:0]        iss_rs2,
    input  logic [DEPTH-1:0]        iss_rd,
    input  logic                    iss_rs1_en,
    input  logic                    iss_rs2_en,
    input  logic                    iss_rd_en,
    output logic                    iss_stall,
    output logic                    rf_we,
    output logic [DEPTH-1:0]        rf_wa,
    output logic [WIDTH-1:0]        rf_wd,
    output logic [(2**DEPTH)-1:0]   pend
);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 2**DEPTH;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             we_q;
    logic [DEPTH-1:0] wa_q, wa_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [NREG-1:0]  pend_q, pend_d;

    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [PW:0]      cand;
    logic             haz_rs1, haz_rs2, haz_waw, fire;

    // Search ptr+1 .. ptr+NREQ with explicit wrap so non-power-of-two NREQ works.
    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_idx   = ptr_q;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (PW+1)'(ptr_q) + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (!gnt_any && req_valid[cand[PW-1:0]]) begin
                gnt_any                   = 1'b1;
                gnt_idx                   = cand[PW-1:0];
                req_ready[cand[PW-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = gnt_any ? gnt_idx : ptr_q;
        wa_d  = gnt_any ? req_wa[gnt_idx*DEPTH +: DEPTH] : wa_q;
        wd_d  = gnt_any ? req_wd[gnt_idx*WIDTH +: WIDTH] : wd_q;
    end

    // A register being written this cycle is forwarded by the file, so it never stalls.
    always_comb begin
        haz_rs1   = iss_rs1_en & pend_q[iss_rs1] & ~(we_q & (wa_q == iss_rs1));
        haz_rs2   = iss_rs2_en & pend_q[iss_rs2] & ~(we_q & (wa_q == iss_rs2));
        haz_waw   = iss_rd_en  & pend_q[iss_rd]  & ~(we_q & (wa_q == iss_rd));
        iss_stall = iss_valid & (haz_rs1 | haz_rs2 | haz_waw);
        fire      = iss_valid & ~iss_stall;
    end

    // Clear first, then set, so a same-cycle reissue to the written register stays pending.
    always_comb begin
        pend_d = pend_q;
        if (we_q)
            pend_d[wa_q] = 1'b0;
        if (fire && iss_rd_en)
            pend_d[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q  <= PW'(NREQ-1);
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= gnt_any;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    assign rf_we = we_q;
    assign rf_wa = wa_q;
    assign rf_wd = wd_q;
    assign pend  = pend_q;
endmodule

// File: tb/tb_fp_wb_sched.sv
// Directed bench for fp_wb_sched: grants are checked as driven and the expected
// write is queued; a monitor pops and compares each register-file write.
module tb_fp_wb_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 5;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DEPTH-1:0] req_wa;
    logic [NREQ*WIDTH-1:0] req_wd;
    logic [NREQ-1:0]       req_ready;
    logic                  iss_valid;
    logic [DEPTH-1:0]      iss_rs1, iss_rs2, iss_rd;
    logic                  iss_rs1_en, iss_rs2_en, iss_rd_en;
    logic                  iss_stall;
    logic                  rf_we;
    logic [DEPTH-1:0]      rf_wa;
    logic [WIDTH-1:0]      rf_wd;
    logic [31:0]           pend;

    logic [DEPTH-1:0]      wa_a [NREQ];
    logic [WIDTH-1:0]      wd_a [NREQ];
    logic [DEPTH+WIDTH-1:0] exp_q [$];
    logic [DEPTH+WIDTH-1:0] e;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_wa[i*DEPTH +: DEPTH] = wa_a[i];
            req_wd[i*WIDTH +: WIDTH] = wd_a[i];
        end
    end

    fp_wb_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_wa(req_wa), .req_wd(req_wd), .req_ready(req_ready),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en), .iss_rd_en(iss_rd_en),
        .iss_stall(iss_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pend(pend)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gnt(input int idx);
        logic [NREQ-1:0] g;
        g = '0;
        g[idx] = 1'b1;
        chk("grant", {60'd0, req_ready}, {60'd0, g});
        exp_q.push_back({wa_a[idx], wd_a[idx]});
    endtask

    // Every accepted grant must appear as exactly one write on the following cycle.
    always begin
        @(posedge clk);
        #1;
        if (rstn === 1'b1) begin
            chk("rf_we", {63'd0, rf_we}, {63'd0, (exp_q.size() > 0)});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_wa", {59'd0, rf_wa}, {59'd0, e[DEPTH+WIDTH-1:WIDTH]});
                chk("rf_wd", {32'd0, rf_wd}, {32'd0, e[WIDTH-1:0]});
            end
        end
    end

    initial begin
        rstn = 1'b0; req_valid = '0; iss_valid = 1'b0;
        iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        iss_rs1_en = 1'b0; iss_rs2_en = 1'b0; iss_rd_en = 1'b0;
        for (int i = 0; i < NREQ; i++) begin wa_a[i] = '0; wd_a[i] = '0; end

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we",    {63'd0, rf_we},     64'd0);
        chk("rst_wa",    {59'd0, rf_wa},     64'd0);
        chk("rst_wd",    {32'd0, rf_wd},     64'd0);
        chk("rst_pend",  {32'd0, pend},      64'd0);
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_stall", {63'd0, iss_stall}, 64'd0);
        @(negedge clk) rstn = 1'b1;

        // all four valid: grants 0,1,2,3 back to back
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            wa_a[i] = DEPTH'(i + 1);
            wd_a[i] = 32'h3F80_0000 + 32'(i);
        end
        req_valid = 4'hF;
        #1 gnt(0);
        for (int i = 1; i < NREQ; i++) begin
            @(negedge clk) req_valid[i-1] = 1'b0;
            #1 gnt(i);
        end
        @(negedge clk) req_valid = '0;
        #1 chk("idle_ready", {60'd0, req_ready}, 64'd0);

        // 1 and 3 continuously valid: alternate
        @(negedge clk);
        wa_a[1] = 5'd10; wd_a[1] = 32'hAAAA_0001;
        wa_a[3] = 5'd11; wd_a[3] = 32'hBBBB_0003;
        req_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            #1 gnt((n % 2) ? 3 : 1);
            @(negedge clk);
        end
        req_valid = '0;

        // RAW on f5, cleared by fmul write with bypass
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rd_en = 1'b1;
        #1 chk("f5_issue_stall", {63'd0, iss_stall}, 64'd0);
        @(negedge clk);
        iss_rd_en = 1'b0; iss_rs1 = 5'd5; iss_rs1_en = 1'b1;
        #1 chk("f5_pend", {32'd0, pend}, 64'h20);
        chk("f5_raw_stall", {63'd0, iss_stall}, 64'd1);
        @(negedge clk);
        wa_a[1] = 5'd5; wd_a[1] = 32'h40A0_0000; req_valid = 4'b0010;
        #1 gnt(1);
        chk("f5_raw_stall2", {63'd0, iss_stall}, 64'd1);
        @(negedge clk) req_valid = '0;
        #1 chk("f5_bypass", {63'd0, iss_stall}, 64'd0);
        chk("f5_pend_hold", {32'd0, pend}, 64'h20);
        @(negedge clk) begin iss_valid = 1'b0; iss_rs1_en = 1'b0; end
        #1 chk("f5_cleared", {32'd0, pend}, 64'd0);

        // f7 written while a new fire re-sets f7: set wins
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd7; iss_rd_en = 1'b1;
        #1 chk("f7_issue_stall", {63'd0, iss_stall}, 64'd0);
        @(negedge clk);
        iss_valid = 1'b0;
        wa_a[0] = 5'd7; wd_a[0] = 32'h0000_1234; req_valid = 4'b0001;
        #1 gnt(0);
        chk("f7_pend", {32'd0, pend}, 64'h80);
        @(negedge clk);
        req_valid = '0; iss_valid = 1'b1;
        #1 chk("f7_waw_bypass", {63'd0, iss_stall}, 64'd0);
        @(negedge clk);
        iss_valid = 1'b0; iss_rd_en = 1'b0;
        wa_a[2] = 5'd7; wd_a[2] = 32'h0000_5678; req_valid = 4'b0100;
        #1 chk("f7_set_wins", {32'd0, pend}, 64'h80);
        gnt(2);
        @(negedge clk) req_valid = '0;
        #1 chk("f7_pend_hold", {32'd0, pend}, 64'h80);
        @(negedge clk);
        #1 chk("f7_cleared", {32'd0, pend}, 64'd0);

        // f0 is tracked like any other register
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rd_en = 1'b1;
        #1 chk("f0_issue_stall", {63'd0, iss_stall}, 64'd0);
        @(negedge clk);
        iss_rd_en = 1'b0; iss_rs2 = 5'd0; iss_rs2_en = 1'b1;
        #1 chk("f0_pend", {32'd0, pend}, 64'h1);
        chk("f0_stall", {63'd0, iss_stall}, 64'd1);
        @(negedge clk);
        #1 chk("f0_stall2", {63'd0, iss_stall}, 64'd1);
        @(negedge clk);
        wa_a[3] = 5'd0; wd_a[3] = 32'h4049_0FDB; req_valid = 4'b1000;
        #1 gnt(3);
        chk("f0_stall3", {63'd0, iss_stall}, 64'd1);
        @(negedge clk) req_valid = '0;
        #1 chk("f0_bypass", {63'd0, iss_stall}, 64'd0);
        @(negedge clk) begin iss_valid = 1'b0; iss_rs2_en = 1'b0; end
        #1 chk("f0_cleared", {32'd0, pend}, 64'd0);

        // reset in the middle of a burst
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd9; iss_rd_en = 1'b1;
        #1 chk("mid_issue_stall", {63'd0, iss_stall}, 64'd0);
        @(negedge clk);
        iss_valid = 1'b0; iss_rd_en = 1'b0;
        wa_a[1] = 5'd12; wd_a[1] = 32'h1111_2222;
        wa_a[2] = 5'd13; wd_a[2] = 32'h3333_4444;
        wa_a[0] = 5'd14; wd_a[0] = 32'h5555_6666;
        req_valid = 4'b0110;
        #1 gnt(1);
        chk("mid_pend", {32'd0, pend}, 64'h200);
        @(negedge clk) req_valid = 4'b0100;
        #1 chk("mid_ready", {60'd0, req_ready}, 64'h4);
        #1 begin rstn = 1'b0; req_valid = 4'b0101; end
        #1;
        chk("mid_rst_we",   {63'd0, rf_we}, 64'd0);
        chk("mid_rst_wa",   {59'd0, rf_wa}, 64'd0);
        chk("mid_rst_wd",   {32'd0, rf_wd}, 64'd0);
        chk("mid_rst_pend", {32'd0, pend},  64'd0);
        @(negedge clk) rstn = 1'b1;
        #1 gnt(0);
        @(negedge clk) req_valid = 4'b0100;
        #1 gnt(2);
        @(negedge clk) req_valid = '0;
        repeat (3) @(negedge clk);
        chk("drain", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/fp_wb_sched.md
Name: fp_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32-entry FP register file (2 read ports, 1 write port with write-to-read bypass).
- Round-robin arbitrates NREQ FP result sources (fadd, fmul, fdiv, flw) onto the single write port, and registers the winner into the file's we/wa/wd.
- Keeps a per-register pending bit and stalls FP issue on RAW/WAW hazards.

Parameters:
- NREQ, 4, number of write-back requesters (index 0 = fadd, 1 = fmul, 2 = fdiv, 3 = flw).
- WIDTH, 32, data width.
- DEPTH, 5, register address width (32 registers).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a result.
- req_wa  in  NREQ*DEPTH  destination of requester i, slice [i*DEPTH +: DEPTH].
- req_wd  in  NREQ*WIDTH  result of requester i, slice [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  grant; requester i's result is accepted this cycle.
- iss_valid  in  1  decode presents an FP instruction.
- iss_rs1, iss_rs2, iss_rd  in  DEPTH each  source and destination registers.
- iss_rs1_en, iss_rs2_en, iss_rd_en  in  1 each  operand or destination is used.
- iss_stall  out  1  hazard; instruction must not issue.
- rf_we  out  1  register-file write enable.
- rf_wa  out  DEPTH  register-file write address.
- rf_wd  out  WIDTH  register-file write data.
- pend  out  32  pending-write vector.

Behaviour:
- Reset (async, rstn=0): rf_we=0, rf_wa=0, rf_wd=0, pend=0, rr pointer=NREQ-1, so requester 0 has top priority first. Reset mid-operation drops any in-flight grant and all pending bits.
- Arbitration (combinational):
  - Search order is ptr+1, ptr+2, … modulo NREQ.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - No valid requester → all req_ready=0.
  - ptr updates to the granted index on a grant and holds otherwise.
- Requester rule: req_valid, req_wa and req_wd stay stable until req_ready=1. Transfer occurs on the cycle where valid&ready are both 1. Valid may drop only after the transfer.
- Write stage (registered, 1-cycle latency):
  - On a grant, the next cycle has rf_we=1 and rf_wa/rf_wd equal to the winner's values.
  - With no grant, rf_we=0 and rf_wa/rf_wd hold their previous values.
  - Back-to-back grants give one write per cycle, with no bubbles.
- Issue fire = iss_valid & ~iss_stall. On fire with iss_rd_en, pend[iss_rd] is set at the next edge.
- Pending clear: when rf_we=1, pend[rf_wa] clears at the next edge.
  - If fire sets the same register in that cycle, set wins and pend stays 1.
  - A write to a non-pending register is performed normally; the clear is a no-op.
- Hazard terms:
  - An operand is hazardous if it is enabled, pend[rs]=1, and not (rf_we & rf_wa==rs). The register file forwards that write, so it is not a hazard.
  - WAW: iss_rd_en & pend[iss_rd] & ~(rf_we & rf_wa==iss_rd).
  - iss_stall = iss_valid & (rs1 hazard | rs2 hazard | WAW).
- All 32 registers, including f0, are writable and trackable.
- Arithmetic: ptr is $clog2(NREQ) bits and wraps modulo NREQ. When NREQ is not a power of two, index NREQ-1+1 wraps to 0 explicitly.

Test Plan:
- Reset, then all four requesters valid, with req_wa=1,2,3,4 and req_wd=0x3F800000+i held → grants in order 0,1,2,3; rf_we=1 on four consecutive cycles, one cycle after each grant, with matching wa/wd.
- Requesters 1 and 3 both continuously valid → grants alternate 1,3,1,3; requester 3 is never starved.
- Issue with rd=f5 → pend[5]=1. Next instruction with rs1=f5 → iss_stall=1. fmul returns wa=5 → in the rf_we cycle iss_stall=0 through bypass; pend[5]=0 after that edge.
- pend[7]=1, rf_we writes f7 while a new fire sets rd=f7 in the same cycle → pend[7] remains 1.
- Issue with rd=f0, then a read of f0 → stall until the write to f0 occurs; f0 write accepted.
- rstn asserted mid-burst while requester 2 is valid and pend≠0 → outputs, pend and ptr return to reset values immediately; after release the first grant goes to 0 if valid, else to 2.
